// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: memory opcodes, load/store width encodings, MEM-stage FSM states.
package pipeline_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        WAIT_RVALID,
        GIVE
    } mem_state_e;

    // Unknown widths count as word accesses, so they need a zero lane.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] lane);
        case (funct3)
            F3_B, F3_BU: is_misaligned = 1'b0;
            F3_H, F3_HU: is_misaligned = lane[0];
            default:     is_misaligned = (lane != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Selects and extends the addressed byte/halfword/word out of a 32-bit read beat.
module load_align
    import pipeline_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'(rdata >> {lane, 3'b000});
        // Halfword selection ignores lane[0]: an odd halfword address is forced aligned.
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data = {24'h0, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data = {16'h0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX handshake in, one data-memory access for loads/stores, WB handshake out.
// Optional MEM_ALIGN_CHECK_EN: misaligned halfword/word accesses bypass memory and are flagged to WB.
module mem_stage
    import pipeline_pkg::*;
#(
    parameter int BITSIZE = 32
) (
    input  logic               clk,
    input  logic               reset_i,
    input  logic               EX_MEM_give_i,
    output logic               MEM_EX_get_o,
    input  logic [31:0]        EX_MEM_instruction_i,
    input  logic [BITSIZE-1:0] EX_MEM_result_i,
    input  logic [BITSIZE-1:0] EX_MEM_rs2_i,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic [BITSIZE-1:0] mem_addr_o,
    output logic [BITSIZE-1:0] mem_wdata_o,
    output logic [3:0]         mem_be_o,
    input  logic               mem_gnt_i,
    input  logic               mem_rvalid_i,
    input  logic [BITSIZE-1:0] mem_rdata_i,
    output logic               MEM_WB_give_o,
    input  logic               WB_MEM_get_i,
    output logic [31:0]        MEM_WB_instruction_o,
    output logic [BITSIZE-1:0] MEM_WB_data_o,
    output logic               MEM_WB_misaligned_o
);

    mem_state_e state, next_state;

    logic [31:0]        instr_q;
    logic [BITSIZE-1:0] result_q, rs2_q, data_q, load_data;
    logic               ex_xfer, wb_xfer, in_is_mem, in_misaligned, q_is_load;
    logic [2:0]         q_funct3;
    logic [1:0]         lane;

    assign ex_xfer   = EX_MEM_give_i & MEM_EX_get_o;
    assign wb_xfer   = MEM_WB_give_o & WB_MEM_get_i;
    assign in_is_mem = (EX_MEM_instruction_i[6:0] == OPC_LOAD) ||
                       (EX_MEM_instruction_i[6:0] == OPC_STORE);
    assign q_is_load = (instr_q[6:0] == OPC_LOAD);
    assign q_funct3  = instr_q[14:12];
    assign lane      = result_q[1:0];

`ifdef MEM_ALIGN_CHECK_EN
    logic misaligned_q;
    assign in_misaligned       = in_is_mem && is_misaligned(EX_MEM_instruction_i[14:12], EX_MEM_result_i[1:0]);
    assign MEM_WB_misaligned_o = misaligned_q;

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i)      misaligned_q <= 1'b0;
        else if (ex_xfer) misaligned_q <= in_misaligned;
    end
`else
    assign in_misaligned       = 1'b0;
    assign MEM_WB_misaligned_o = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:        if (ex_xfer) next_state = (in_is_mem && !in_misaligned) ? REQUEST : GIVE;
            REQUEST:     if (mem_gnt_i) next_state = q_is_load ? WAIT_RVALID : GIVE;
            WAIT_RVALID: if (mem_rvalid_i) next_state = GIVE;
            GIVE:        if (wb_xfer) next_state = IDLE;
            default:     next_state = IDLE;
        endcase
    end

    // Request-side outputs decode straight from state so an async reset drops them at once.
    always_comb begin
        MEM_EX_get_o  = (state == IDLE) && !reset_i;
        MEM_WB_give_o = (state == GIVE);
        mem_req_o     = (state == REQUEST);
        mem_we_o      = (state == REQUEST) && !q_is_load;
        mem_be_o      = 4'b0000;
        mem_wdata_o   = rs2_q;
        if (state == REQUEST) begin
            mem_be_o = 4'b1111;
            if (!q_is_load) begin
                case (q_funct3)
                    F3_B: begin
                        mem_be_o    = 4'b0001 << lane;
                        mem_wdata_o = {4{rs2_q[7:0]}};
                    end
                    F3_H: begin
                        mem_be_o    = lane[1] ? 4'b1100 : 4'b0011;
                        mem_wdata_o = {2{rs2_q[15:0]}};
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mem_addr_o           = {result_q[BITSIZE-1:2], 2'b00};
    assign MEM_WB_instruction_o = instr_q;
    assign MEM_WB_data_o        = data_q;

    load_align u_load_align (
        .rdata  (mem_rdata_i),
        .lane   (lane),
        .funct3 (q_funct3),
        .data   (load_data)
    );

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            instr_q  <= '0;
            result_q <= '0;
            rs2_q    <= '0;
            data_q   <= '0;
        end else if (ex_xfer) begin
            instr_q  <= EX_MEM_instruction_i;
            result_q <= EX_MEM_result_i;
            rs2_q    <= EX_MEM_rs2_i;
            data_q   <= EX_MEM_result_i;
        end else if (state == WAIT_RVALID && mem_rvalid_i) begin
            data_q   <= load_data;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, loads, stores, WB backpressure, reset mid-access, misalignment.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        ex_give, ex_get;
    logic [31:0] ex_instr, ex_result, ex_rs2;
    logic        req, we, gnt, rvalid;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  be;
    logic        wb_give, wb_get, misaligned;
    logic [31:0] wb_instr, wb_data;

    int checks = 0;
    int failures = 0;

    localparam logic [31:0] I_ADD = 32'h0000_0033;
    localparam logic [31:0] I_LB  = 32'h0000_0003;
    localparam logic [31:0] I_LBU = 32'h0000_4003;
    localparam logic [31:0] I_LW  = 32'h0000_2003;
    localparam logic [31:0] I_SB  = 32'h0000_0023;
    localparam logic [31:0] I_SH  = 32'h0000_1023;

    always #5 clk = ~clk;

    mem_stage #(.BITSIZE(32)) dut (
        .clk                  (clk),
        .reset_i              (reset_i),
        .EX_MEM_give_i        (ex_give),
        .MEM_EX_get_o         (ex_get),
        .EX_MEM_instruction_i (ex_instr),
        .EX_MEM_result_i      (ex_result),
        .EX_MEM_rs2_i         (ex_rs2),
        .mem_req_o            (req),
        .mem_we_o             (we),
        .mem_addr_o           (addr),
        .mem_wdata_o          (wdata),
        .mem_be_o             (be),
        .mem_gnt_i            (gnt),
        .mem_rvalid_i         (rvalid),
        .mem_rdata_i          (rdata),
        .MEM_WB_give_o        (wb_give),
        .WB_MEM_get_i         (wb_get),
        .MEM_WB_instruction_o (wb_instr),
        .MEM_WB_data_o        (wb_data),
        .MEM_WB_misaligned_o  (misaligned)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Offer one instruction at a negedge; returns at the next negedge, after the transfer edge.
    task automatic send(input logic [31:0] instr, input logic [31:0] res, input logic [31:0] rs2);
        chk("ex_get_before_send", {31'b0, ex_get}, 32'd1);
        ex_give = 1'b1; ex_instr = instr; ex_result = res; ex_rs2 = rs2;
        @(negedge clk);
        ex_give = 1'b0;
    endtask

    // Load with same-cycle gnt and next-cycle rvalid; checks the request beat and the WB result.
    task automatic run_load(input string tag, input logic [31:0] instr, input logic [31:0] res,
                            input logic [31:0] rd, input logic [31:0] exp_addr, input logic [31:0] exp_data);
        send(instr, res, 32'h0);
        chk({tag, "_req"}, {31'b0, req}, 32'd1);
        chk({tag, "_addr"}, addr, exp_addr);
        chk({tag, "_be_we"}, {27'b0, be, we}, {27'b0, 4'b1111, 1'b0});
        chk({tag, "_give_early"}, {31'b0, wb_give}, 32'd0);
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        chk({tag, "_req_after_gnt"}, {31'b0, req}, 32'd0);
        rvalid = 1'b1; rdata = rd;
        @(negedge clk);
        rvalid = 1'b0; rdata = 32'h0;
        chk({tag, "_give"}, {31'b0, wb_give}, 32'd1);
        chk({tag, "_data"}, wb_data, exp_data);
        chk({tag, "_instr"}, wb_instr, instr);
        chk({tag, "_misaligned"}, {31'b0, misaligned}, 32'd0);
        @(negedge clk);
        chk({tag, "_idle"}, {30'b0, wb_give, ex_get}, 32'd1);
    endtask

    initial begin
        reset_i = 1'b1; ex_give = 1'b0; ex_instr = '0; ex_result = '0; ex_rs2 = '0;
        gnt = 1'b0; rvalid = 1'b0; rdata = '0; wb_get = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_get", {31'b0, ex_get}, 32'd0);
        chk("rst_ctrl", {28'b0, req, we, wb_give, misaligned}, 32'd0);
        chk("rst_be", {28'b0, be}, 32'd0);
        chk("rst_data", wb_data, 32'd0);
        chk("rst_instr", wb_instr, 32'd0);
        reset_i = 1'b0;
        @(negedge clk);
        chk("post_rst_get", {31'b0, ex_get}, 32'd1);

        // ADD pass-through: offered one cycle after the EX transfer
        send(I_ADD, 32'h0000_1234, 32'h0);
        chk("add_give", {31'b0, wb_give}, 32'd1);
        chk("add_data", wb_data, 32'h0000_1234);
        chk("add_noreq", {31'b0, req}, 32'd0);
        chk("add_get_busy", {31'b0, ex_get}, 32'd0);
        @(negedge clk);
        chk("add_idle", {30'b0, wb_give, ex_get}, 32'd1);

        // Sign/zero-extended byte loads from lane 3
        run_load("lb", I_LB, 32'h0000_0103, 32'h80FF_0000, 32'h0000_0100, 32'hFFFF_FF80);
        run_load("lbu", I_LBU, 32'h0000_0103, 32'h80FF_0000, 32'h0000_0100, 32'h0000_0080);

        // SH with gnt delayed 3 cycles: request held 4 cycles, stable
        send(I_SH, 32'h0000_0202, 32'h0000_ABCD);
        for (int i = 0; i < 4; i++) begin
            chk("sh_req", {31'b0, req}, 32'd1);
            chk("sh_we", {31'b0, we}, 32'd1);
            chk("sh_addr", addr, 32'h0000_0200);
            chk("sh_be", {28'b0, be}, 32'h0000_000C);
            chk("sh_wdata", wdata, 32'hABCD_ABCD);
            chk("sh_nogive", {31'b0, wb_give}, 32'd0);
            if (i == 3) gnt = 1'b1;
            @(negedge clk);
        end
        gnt = 1'b0;
        chk("sh_give", {31'b0, wb_give}, 32'd1);
        chk("sh_req_drop", {31'b0, req}, 32'd0);
        chk("sh_data", wb_data, 32'h0000_0202);
        @(negedge clk);

        // SB at lane 1
        send(I_SB, 32'h0000_0201, 32'h0000_005A);
        chk("sb_be", {28'b0, be}, 32'h0000_0002);
        chk("sb_wdata", wdata, 32'h5A5A_5A5A);
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        chk("sb_give", {31'b0, wb_give}, 32'd1);
        @(negedge clk);

        // LW with WB backpressure for 5 cycles
        wb_get = 1'b0;
        send(I_LW, 32'h0000_0300, 32'h0);
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        rvalid = 1'b0; rdata = 32'h1111_1111;
        for (int i = 0; i < 5; i++) begin
            chk("lw_bp_give", {31'b0, wb_give}, 32'd1);
            chk("lw_bp_data", wb_data, 32'hDEAD_BEEF);
            chk("lw_bp_get", {31'b0, ex_get}, 32'd0);
            @(negedge clk);
        end
        wb_get = 1'b1;
        @(negedge clk);
        chk("lw_bp_release", {30'b0, wb_give, ex_get}, 32'd1);

        // Reset mid-REQUEST, then a stray rvalid
        send(I_LW, 32'h0000_0400, 32'h0);
        chk("rstmid_req", {31'b0, req}, 32'd1);
        #1 reset_i = 1'b1;
        #1 chk("rstmid_req_async", {31'b0, req}, 32'd0);
        @(negedge clk);
        reset_i = 1'b0; rvalid = 1'b1; rdata = 32'hCAFE_F00D;
        @(negedge clk);
        rvalid = 1'b0;
        chk("rstmid_idle", {29'b0, req, wb_give, ex_get}, 32'd1);
        chk("rstmid_data", wb_data, 32'd0);
        @(negedge clk);
        chk("rstmid_nogive", {31'b0, wb_give}, 32'd0);

        // LW at 0x101
`ifdef MEM_ALIGN_CHECK_EN
        send(I_LW, 32'h0000_0101, 32'h0);
        chk("mis_noreq", {31'b0, req}, 32'd0);
        chk("mis_give", {31'b0, wb_give}, 32'd1);
        chk("mis_flag", {31'b0, misaligned}, 32'd1);
        chk("mis_data", wb_data, 32'h0000_0101);
        @(negedge clk);
`else
        run_load("mis_lw", I_LW, 32'h0000_0101, 32'h1122_3344, 32'h0000_0100, 32'h1122_3344);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
